// File: rtl/square_motion_ctrl.sv
// ---------------------------------------------------------------------------
// square_motion_ctrl : frame-synchronous square offset controller (bounce/seek)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module square_motion_ctrl #(
  parameter int X_LIM  = 1055,
  parameter int Y_LIM  = 524,
  parameter int H_ACT  = 800,
  parameter int V_ACT  = 480,
  parameter int SQ_LEN = 100,
  parameter int STEP   = 2,
  parameter int X_INIT = 100,
  parameter int Y_INIT = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] Xpos,
  input  logic [9:0]  Ypos,
  input  logic        enable,
  input  logic        req_valid,
  input  logic [10:0] req_x,
  input  logic [9:0]  req_y,
  output logic        req_ready,
  output logic [10:0] sq_x,
  output logic [9:0]  sq_y,
  output logic        frame_tick,
  output logic [1:0]  mode
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_SEEK = 2'd2
  } state_t;

  localparam int c_XMAX = H_ACT - 1 - SQ_LEN;
  localparam int c_YMAX = V_ACT - 1 - SQ_LEN;

  localparam logic signed [11:0] c_XMAX_S = 12'(c_XMAX);
  localparam logic signed [10:0] c_YMAX_S = 11'(c_YMAX);
  localparam logic signed [11:0] c_STEP_X = 12'(STEP);
  localparam logic signed [10:0] c_STEP_Y = 11'(STEP);

  state_t      state_q, state_d;
  logic [10:0] sq_x_q, sq_x_d;
  logic [9:0]  sq_y_q, sq_y_d;
  logic [10:0] tgt_x_q, tgt_x_d;
  logic [9:0]  tgt_y_q, tgt_y_d;
  logic        dir_x_q, dir_x_d;
  logic        dir_y_q, dir_y_d;
  logic        tick_q;

  logic               w_boundary;
  logic               w_accept;
  logic signed [11:0] w_bx;
  logic signed [10:0] w_by;
  logic signed [11:0] w_dx;
  logic signed [10:0] w_dy;
  logic [10:0]        w_sx;
  logic [9:0]         w_sy;

  assign w_boundary = (Xpos == 11'(X_LIM)) && (Ypos == 10'(Y_LIM));
  assign w_accept   = req_valid && (state_q != ST_SEEK);

  // One extra bit of signed headroom so a step below zero shows up as negative.
  assign w_bx = $signed({1'b0, sq_x_q}) + (dir_x_q ? c_STEP_X : -c_STEP_X);
  assign w_by = $signed({1'b0, sq_y_q}) + (dir_y_q ? c_STEP_Y : -c_STEP_Y);
  assign w_dx = $signed({1'b0, tgt_x_q}) - $signed({1'b0, sq_x_q});
  assign w_dy = $signed({1'b0, tgt_y_q}) - $signed({1'b0, sq_y_q});

  assign w_sx = (w_dx > c_STEP_X)  ? sq_x_q + 11'(STEP) :
                (w_dx < -c_STEP_X) ? sq_x_q - 11'(STEP) : tgt_x_q;
  assign w_sy = (w_dy > c_STEP_Y)  ? sq_y_q + 10'(STEP) :
                (w_dy < -c_STEP_Y) ? sq_y_q - 10'(STEP) : tgt_y_q;

  always_comb begin
    state_d = state_q;
    sq_x_d  = sq_x_q;
    sq_y_d  = sq_y_q;
    tgt_x_d = tgt_x_q;
    tgt_y_d = tgt_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;

    if (w_accept) begin
      state_d = ST_SEEK;
      tgt_x_d = (req_x > 11'(c_XMAX)) ? 11'(c_XMAX) : req_x;
      tgt_y_d = (req_y > 10'(c_YMAX)) ? 10'(c_YMAX) : req_y;
    end else if (w_boundary) begin
      case (state_q)
        ST_IDLE: begin
          if (enable) state_d = ST_MOVE;
        end
        ST_MOVE: begin
          if (!enable) begin
            state_d = ST_IDLE;
          end else begin
            if (w_bx > c_XMAX_S) begin
              sq_x_d  = 11'(c_XMAX);
              dir_x_d = 1'b0;
            end else if (w_bx < 12'sd0) begin
              sq_x_d  = 11'd0;
              dir_x_d = 1'b1;
            end else begin
              sq_x_d  = w_bx[10:0];
            end
            if (w_by > c_YMAX_S) begin
              sq_y_d  = 10'(c_YMAX);
              dir_y_d = 1'b0;
            end else if (w_by < 11'sd0) begin
              sq_y_d  = 10'd0;
              dir_y_d = 1'b1;
            end else begin
              sq_y_d  = w_by[9:0];
            end
          end
        end
        ST_SEEK: begin
          sq_x_d = w_sx;
          sq_y_d = w_sy;
          if ((w_sx == tgt_x_q) && (w_sy == tgt_y_q)) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sq_x_q  <= 11'(X_INIT);
      sq_y_q  <= 10'(Y_INIT);
      tgt_x_q <= 11'd0;
      tgt_y_q <= 10'd0;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sq_x_q  <= sq_x_d;
      sq_y_q  <= sq_y_d;
      tgt_x_q <= tgt_x_d;
      tgt_y_q <= tgt_y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      tick_q  <= w_boundary;
    end
  end

  assign req_ready  = (state_q != ST_SEEK);
  assign sq_x       = sq_x_q;
  assign sq_y       = sq_y_q;
  assign frame_tick = tick_q;
  assign mode       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_square_motion_ctrl.sv
// ---------------------------------------------------------------------------
// tb_square_motion_ctrl : scoreboard bench for square_motion_ctrl (short frames)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_square_motion_ctrl;

  localparam int X_LIM = 7;
  localparam int Y_LIM = 3;
  localparam int FRAME = (X_LIM + 1) * (Y_LIM + 1);

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] Xpos;
  logic [9:0]  Ypos;
  logic        enable;
  logic        req_valid;
  logic [10:0] req_x;
  logic [9:0]  req_y;
  logic        req_ready;
  logic [10:0] sq_x;
  logic [9:0]  sq_y;
  logic        frame_tick;
  logic [1:0]  mode;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic [1:0]  m;
  } exp_t;

  exp_t q[$];
  int   vectors    = 0;
  int   errors     = 0;
  int   tick_count = 0;

  always #5 clk = ~clk;

  square_motion_ctrl #(
    .X_LIM(X_LIM),
    .Y_LIM(Y_LIM)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Xpos      (Xpos),
    .Ypos      (Ypos),
    .enable    (enable),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .sq_x      (sq_x),
    .sq_y      (sq_y),
    .frame_tick(frame_tick),
    .mode      (mode)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int x, input int y, input int m);
    exp_t e;
    e.x = 11'(x);
    e.y = 10'(y);
    e.m = 2'(m);
    q.push_back(e);
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_sq_x"}, sq_x, 100);
    check({tag, "_sq_y"}, sq_y, 100);
    check({tag, "_mode"}, mode, 0);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_frame_tick"}, frame_tick, 0);
  endtask

  task automatic wait_ticks(input int target);
    int budget;
    budget = (target - tick_count + 1) * FRAME + 50;
    for (int i = 0; i < budget && tick_count < target; i++) begin
      @(posedge clk);
      #2;
    end
    if (tick_count < target) begin
      vectors++;
      errors++;
      $display("FAIL tick_timeout: got %0d ticks, expected %0d", tick_count, target);
    end
  endtask

  // Park on the third pixel of a frame so input changes are far from a boundary.
  task automatic sync_mid();
    for (int i = 0; i < FRAME + 4; i++) begin
      @(posedge clk);
      #2;
      if (Xpos == 11'd2 && Ypos == 10'd0) break;
    end
    @(negedge clk);
  endtask

  task automatic reset_pulse(input string tag);
    int base;
    repeat ($urandom_range(2, 20)) @(posedge clk);
    #2 reset = 1'b1;
    #1 check_rst(tag);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base = tick_count;
    push(100, 100, 0);
    wait_ticks(base + 1);
  endtask

  function automatic int bounce_x(input int k);
    if (k <= 299) return 100 + 2 * k;
    if (k == 300) return 699;
    return 699 - 2 * (k - 300);
  endfunction

  function automatic int bounce_y(input int k);
    if (k <= 139) return 100 + 2 * k;
    if (k == 140) return 379;
    return 379 - 2 * (k - 140);
  endfunction

  initial begin
    Xpos = '0;
    Ypos = '0;
    forever begin
      @(negedge clk);
      if (Xpos == 11'(X_LIM)) begin
        Xpos = '0;
        Ypos = (Ypos == 10'(Y_LIM)) ? 10'd0 : Ypos + 10'd1;
      end else begin
        Xpos = Xpos + 11'd1;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (frame_tick === 1'b1) begin
        tick_count++;
        if (q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_tick: got tick with sq=(%0d,%0d) mode=%0d, expected none",
                   sq_x, sq_y, mode);
        end else begin
          e = q.pop_front();
          check("tick_sq_x", sq_x, e.x);
          check("tick_sq_y", sq_y, e.y);
          check("tick_mode", mode, e.m);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    reset     = 1'b1;
    enable    = 1'b0;
    req_valid = 1'b0;
    req_x     = '0;
    req_y     = '0;
    repeat (3) @(posedge clk);
    #1 check_rst("init");
    @(negedge clk);
    reset = 1'b0;

    // Idle frames: ticks arrive but nothing moves.
    base = tick_count;
    repeat (3) push(100, 100, 0);
    wait_ticks(base + 3);

    // Bounce.
    sync_mid();
    enable = 1'b1;
    base   = tick_count;
    push(100, 100, 1);
    for (int k = 1; k <= 302; k++) push(bounce_x(k), bounce_y(k), 1);
    wait_ticks(base + 303);
    sync_mid();
    enable = 1'b0;
    push(695, 55, 0);
    push(695, 55, 0);
    wait_ticks(base + 305);
    reset_pulse("rst_after_bounce");

    // Seek to (300,50), with an ignored second request in flight.
    sync_mid();
    req_valid = 1'b1;
    req_x     = 11'd300;
    req_y     = 10'd50;
    base      = tick_count;
    for (int k = 1; k <= 100; k++)
      push(100 + 2 * k, (k < 25) ? 100 - 2 * k : 50, (k == 100) ? 0 : 2);
    @(posedge clk);
    #1;
    check("seek_req_ready", req_ready, 0);
    check("seek_mode", mode, 2);
    @(negedge clk);
    req_valid = 1'b0;
    wait_ticks(base + 10);
    sync_mid();
    req_valid = 1'b1;
    req_x     = 11'd5;
    req_y     = 10'd5;
    repeat (20) @(negedge clk);
    check("seek_busy_ready", req_ready, 0);
    repeat (20) @(negedge clk);
    req_valid = 1'b0;
    wait_ticks(base + 100);
    check("seek_done_ready", req_ready, 1);
    check("seek_done_mode", mode, 0);
    reset_pulse("rst_after_seek");

    // Clamped target, odd final x step.
    sync_mid();
    req_valid = 1'b1;
    req_x     = 11'd1000;
    req_y     = 10'd600;
    base      = tick_count;
    for (int k = 1; k <= 300; k++)
      push((k < 300) ? 100 + 2 * k : 699, (k < 140) ? 100 + 2 * k : 379, (k == 300) ? 0 : 2);
    @(negedge clk);
    req_valid = 1'b0;
    wait_ticks(base + 300);
    reset_pulse("rst_after_clamp");

    // Acceptance coinciding with a boundary cycle.
    for (int i = 0; i < FRAME + 4; i++) begin
      @(posedge clk);
      #1;
      if (Xpos == 11'(X_LIM - 1) && Ypos == 10'(Y_LIM)) break;
    end
    req_valid = 1'b1;
    req_x     = 11'd100;
    req_y     = 10'd100;
    base      = tick_count;
    push(100, 100, 2);
    push(100, 100, 0);
    @(posedge clk);
    #2;
    check("coinc_mode", mode, 2);
    @(negedge clk);
    req_valid = 1'b0;
    wait_ticks(base + 2);

    // Reset in the middle of a seek.
    sync_mid();
    req_valid = 1'b1;
    req_x     = 11'd300;
    req_y     = 10'd50;
    base      = tick_count;
    for (int k = 1; k <= 5; k++) push(100 + 2 * k, 100 - 2 * k, 2);
    @(negedge clk);
    req_valid = 1'b0;
    wait_ticks(base + 5);
    check("preseek_rst_sq_x", sq_x, 110);
    reset_pulse("rst_mid_seek");

    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
